// File: rtl/vai_tx_throttle.sv
// vai_tx_throttle: per-AFU credit and flow-control stage between the VAI mux
// ports and the VTP wrapper ports.
//
// c0 (read) and c1 (write) requests are buffered in per-channel FIFOs and
// released downstream only when the downstream almost-full is low and the
// outstanding-line credit allows it. This stops one nested AFU from
// monopolising VTP translation and FIU bandwidth. Rx responses and c2 MMIO
// responses are passed through with one register stage.
//
// Ports:
//   pClk                   CCI-P clock, all logic on the rising edge
//   pck_cp2af_softReset_n  synchronous active-low reset
//   up_TxPort   (in)       requests from the VAI mux
//   up_RxPort   (out)      responses and almost-full flags to the VAI mux
//   dn_TxPort   (out)      requests to the VTP wrapper
//   dn_RxPort   (in)       responses from the VTP wrapper
//   rd_outstanding (out)   outstanding read lines
//   wr_outstanding (out)   outstanding write lines
//   err_sticky     (out)   bit0 FIFO overflow, bit1 credit underflow
//
// Optional build macro VAI_TX_THROTTLE_STATS_EN adds rd_stall_cycles and
// wr_stall_cycles: wrapping counts of cycles where a non-empty FIFO head is
// held back by credit (almost-full stalls are not counted).
//
// Write FSM:
//   state   | meaning
//   W_IDLE  | next c1 head is an sop beat (or a stray non-sop beat)
//   W_BURST | mid multi-line write, remaining beats issue without credit check

package vai_ccip_pkg;

  localparam logic [3:0] RSP_RDLINE = 4'h0;
  localparam logic [3:0] RSP_WRLINE = 4'h1;

  typedef struct packed {
    logic [3:0]  req_type;
    logic [1:0]  cl_len;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_c0_req_hdr;

  typedef struct packed {
    logic [3:0]  req_type;
    logic        sop;
    logic [1:0]  cl_len;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_c1_req_hdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_c2_rsp_hdr;

  typedef struct packed {
    t_c0_req_hdr hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_c1_req_hdr  hdr;
    logic [511:0] data;
    logic         valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_c2_rsp_hdr hdr;
    logic [63:0] data;
    logic        mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    logic [3:0]  resp_type;
    logic [1:0]  cl_num;
    logic [15:0] mdata;
  } t_c0_rsp_hdr;

  typedef struct packed {
    logic [3:0]  resp_type;
    logic        format;
    logic [1:0]  cl_num;
    logic [15:0] mdata;
  } t_c1_rsp_hdr;

  typedef struct packed {
    t_c0_rsp_hdr  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_c1_rsp_hdr hdr;
    logic        rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

endpackage

module vai_tx_throttle
  import vai_ccip_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 8,
  parameter int MAX_RD_LINES  = 64,
  parameter int MAX_WR_LINES  = 64
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset_n,
  input  t_if_ccip_Tx up_TxPort,
  output t_if_ccip_Rx up_RxPort,
  output t_if_ccip_Tx dn_TxPort,
  input  t_if_ccip_Rx dn_RxPort,
  output logic [7:0]  rd_outstanding,
  output logic [7:0]  wr_outstanding,
  output logic [1:0]  err_sticky
`ifdef VAI_TX_THROTTLE_STATS_EN
  ,
  output logic [31:0] rd_stall_cycles,
  output logic [31:0] wr_stall_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    t_c1_req_hdr  hdr;
    logic [511:0] data;
  } c1_entry_t;

  typedef enum logic {W_IDLE, W_BURST} wr_state_e;

  // FIFO storage (pointers carry the reset; contents need none)
  t_c0_req_hdr c0_mem [FIFO_DEPTH];
  c1_entry_t   c1_mem [FIFO_DEPTH];

  logic [AW-1:0] c0_wr_ptr_q, c0_wr_ptr_d, c0_rd_ptr_q, c0_rd_ptr_d;
  logic [AW-1:0] c1_wr_ptr_q, c1_wr_ptr_d, c1_rd_ptr_q, c1_rd_ptr_d;
  logic [CW-1:0] c0_cnt_q, c0_cnt_d, c1_cnt_q, c1_cnt_d;

  logic up_alm0_q, up_alm0_d, up_alm1_q, up_alm1_d;
  logic [7:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic [1:0] err_q, err_d;
  wr_state_e  wr_state_q, wr_state_d;
  logic [1:0] beats_q, beats_d;

  t_if_ccip_c0_Tx dn_c0_q, dn_c0_d;
  t_if_ccip_c1_Tx dn_c1_q, dn_c1_d;
  t_if_ccip_c2_Tx dn_c2_q, dn_c2_d;
  t_if_ccip_c0_Rx up_c0_q, up_c0_d;
  t_if_ccip_c1_Rx up_c1_q, up_c1_d;

  logic        c0_empty, c0_full, c1_empty, c1_full;
  logic        c0_push, c1_push, c0_ovf, c1_ovf;
  t_c0_req_hdr c0_head;
  c1_entry_t   c1_head;

  logic [8:0]  rd_len, wr_len, rd_sum, wr_sum, rd_sub, wr_sub;
  logic        rd_credit_ok, wr_credit_ok;
  logic        rd_issue, wr_issue, rd_blk, wr_blk;
  logic [8:0]  wr_add;
  logic        rd_unf, wr_unf;

  assign c0_empty = (c0_cnt_q == '0);
  assign c1_empty = (c1_cnt_q == '0);
  assign c0_full  = (c0_cnt_q == CW'(FIFO_DEPTH));
  assign c1_full  = (c1_cnt_q == CW'(FIFO_DEPTH));
  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign c0_push  = up_TxPort.c0.valid && !c0_full;
  assign c1_push  = up_TxPort.c1.valid && !c1_full;
  assign c0_ovf   = up_TxPort.c0.valid && c0_full;
  assign c1_ovf   = up_TxPort.c1.valid && c1_full;
  assign c0_head  = c0_mem[c0_rd_ptr_q];
  assign c1_head  = c1_mem[c1_rd_ptr_q];

  // Read issue
  assign rd_len       = {7'd0, c0_head.cl_len} + 9'd1;
  assign rd_credit_ok = ({1'b0, rd_out_q} + rd_len) <= 9'(MAX_RD_LINES);
  assign rd_issue     = !c0_empty && !dn_RxPort.c0TxAlmFull && rd_credit_ok;
  assign rd_blk       = !c0_empty && !dn_RxPort.c0TxAlmFull && !rd_credit_ok;

  // Write issue
  assign wr_len       = {7'd0, c1_head.hdr.cl_len} + 9'd1;
  assign wr_credit_ok = ({1'b0, wr_out_q} + wr_len) <= 9'(MAX_WR_LINES);

  always_comb begin
    wr_state_d = wr_state_q;
    beats_d    = beats_q;
    wr_issue   = 1'b0;
    wr_add     = '0;
    wr_blk     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (!c1_empty && !dn_RxPort.c1TxAlmFull) begin
          if (c1_head.hdr.sop) begin
            if (wr_credit_ok) begin
              wr_issue = 1'b1;
              wr_add   = wr_len;
              if (c1_head.hdr.cl_len != 2'd0) begin
                wr_state_d = W_BURST;
                beats_d    = c1_head.hdr.cl_len;
              end
            end else begin
              wr_blk = 1'b1;
            end
          end else begin
            // stray non-sop beat: forward without touching credit
            wr_issue = 1'b1;
          end
        end
      end
      W_BURST: begin
        if (!c1_empty && !dn_RxPort.c1TxAlmFull) begin
          wr_issue = 1'b1;
          beats_d  = beats_q - 2'd1;
          if (beats_q == 2'd1) wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Credit accounting: issue and return in the same cycle net out; an
  // excess return saturates at zero and flags an underflow.
  always_comb begin
    rd_sub = (dn_RxPort.c0.rspValid && dn_RxPort.c0.hdr.resp_type == RSP_RDLINE)
             ? 9'd1 : 9'd0;
    wr_sub = '0;
    if (dn_RxPort.c1.rspValid && dn_RxPort.c1.hdr.resp_type == RSP_WRLINE)
      wr_sub = dn_RxPort.c1.hdr.format ? ({7'd0, dn_RxPort.c1.hdr.cl_num} + 9'd1) : 9'd1;
    rd_sum = {1'b0, rd_out_q} + (rd_issue ? rd_len : 9'd0);
    wr_sum = {1'b0, wr_out_q} + wr_add;
    rd_unf = (rd_sum < rd_sub);
    wr_unf = (wr_sum < wr_sub);
    rd_out_d = rd_unf ? 8'd0 : 8'(rd_sum - rd_sub);
    wr_out_d = wr_unf ? 8'd0 : 8'(wr_sum - wr_sub);
    err_d = err_q | {rd_unf | wr_unf, c0_ovf | c1_ovf};
  end

  // FIFO pointers, occupancy and upstream almost-full
  always_comb begin
    c0_wr_ptr_d = c0_wr_ptr_q + AW'(c0_push);
    c1_wr_ptr_d = c1_wr_ptr_q + AW'(c1_push);
    c0_rd_ptr_d = c0_rd_ptr_q + AW'(rd_issue);
    c1_rd_ptr_d = c1_rd_ptr_q + AW'(wr_issue);
    c0_cnt_d    = c0_cnt_q + CW'(c0_push) - CW'(rd_issue);
    c1_cnt_d    = c1_cnt_q + CW'(c1_push) - CW'(wr_issue);
    // based on next occupancy so the flag reflects this cycle's pushes
    up_alm0_d   = (CW'(FIFO_DEPTH) - c0_cnt_d) <= CW'(ALMFULL_SLACK);
    up_alm1_d   = (CW'(FIFO_DEPTH) - c1_cnt_d) <= CW'(ALMFULL_SLACK);
  end

  always_comb begin
    dn_c0_d       = '0;
    dn_c0_d.hdr   = c0_head;
    dn_c0_d.valid = rd_issue;
    dn_c1_d       = '0;
    dn_c1_d.hdr   = c1_head.hdr;
    dn_c1_d.data  = c1_head.data;
    dn_c1_d.valid = wr_issue;
    dn_c2_d       = up_TxPort.c2;
    up_c0_d       = dn_RxPort.c0;
    up_c1_d       = dn_RxPort.c1;
  end

  always_ff @(posedge pClk) begin
    if (c0_push) c0_mem[c0_wr_ptr_q] <= up_TxPort.c0.hdr;
    if (c1_push) c1_mem[c1_wr_ptr_q] <= '{hdr: up_TxPort.c1.hdr, data: up_TxPort.c1.data};
  end

  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      c0_wr_ptr_q <= '0;
      c0_rd_ptr_q <= '0;
      c1_wr_ptr_q <= '0;
      c1_rd_ptr_q <= '0;
      c0_cnt_q    <= '0;
      c1_cnt_q    <= '0;
      up_alm0_q   <= 1'b1;
      up_alm1_q   <= 1'b1;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
      err_q       <= '0;
      wr_state_q  <= W_IDLE;
      beats_q     <= '0;
      dn_c0_q     <= '0;
      dn_c1_q     <= '0;
      dn_c2_q     <= '0;
      up_c0_q     <= '0;
      up_c1_q     <= '0;
    end else begin
      c0_wr_ptr_q <= c0_wr_ptr_d;
      c0_rd_ptr_q <= c0_rd_ptr_d;
      c1_wr_ptr_q <= c1_wr_ptr_d;
      c1_rd_ptr_q <= c1_rd_ptr_d;
      c0_cnt_q    <= c0_cnt_d;
      c1_cnt_q    <= c1_cnt_d;
      up_alm0_q   <= up_alm0_d;
      up_alm1_q   <= up_alm1_d;
      rd_out_q    <= rd_out_d;
      wr_out_q    <= wr_out_d;
      err_q       <= err_d;
      wr_state_q  <= wr_state_d;
      beats_q     <= beats_d;
      dn_c0_q     <= dn_c0_d;
      dn_c1_q     <= dn_c1_d;
      dn_c2_q     <= dn_c2_d;
      up_c0_q     <= up_c0_d;
      up_c1_q     <= up_c1_d;
    end
  end

`ifdef VAI_TX_THROTTLE_STATS_EN
  logic [31:0] rd_stall_q, rd_stall_d, wr_stall_q, wr_stall_d;

  always_comb begin
    rd_stall_d = rd_stall_q + {31'd0, rd_blk};
    wr_stall_d = wr_stall_q + {31'd0, wr_blk};
  end

  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  assign rd_stall_cycles = rd_stall_q;
  assign wr_stall_cycles = wr_stall_q;
`else
  logic unused_stall;
  assign unused_stall = rd_blk ^ wr_blk;
`endif

  always_comb begin
    dn_TxPort    = '0;
    dn_TxPort.c0 = dn_c0_q;
    dn_TxPort.c1 = dn_c1_q;
    dn_TxPort.c2 = dn_c2_q;
    up_RxPort             = '0;
    up_RxPort.c0TxAlmFull = up_alm0_q;
    up_RxPort.c1TxAlmFull = up_alm1_q;
    up_RxPort.c0          = up_c0_q;
    up_RxPort.c1          = up_c1_q;
  end

  assign rd_outstanding = rd_out_q;
  assign wr_outstanding = wr_out_q;
  assign err_sticky     = err_q;

endmodule

// File: tb/tb_vai_tx_throttle.sv
module tb_vai_tx_throttle;
  import vai_ccip_pkg::*;

  logic        pClk = 1'b0;
  logic        rst_n;
  t_if_ccip_Tx up_tx;
  t_if_ccip_Rx up_rx;
  t_if_ccip_Tx dn_tx;
  t_if_ccip_Rx dn_rx;
  logic [7:0]  rd_out, wr_out;
  logic [1:0]  err;
`ifdef VAI_TX_THROTTLE_STATS_EN
  logic [31:0] rd_stall, wr_stall;
`endif

  int checks = 0;
  int errors = 0;

  int unsigned c0_seen = 0;
  int unsigned c1_seen = 0;
  logic [15:0] last_c0_mdata = '0;
  int unsigned base;

  always #5 pClk = ~pClk;

  vai_tx_throttle #(
    .FIFO_DEPTH(16), .ALMFULL_SLACK(8), .MAX_RD_LINES(16), .MAX_WR_LINES(64)
  ) dut (
    .pClk(pClk),
    .pck_cp2af_softReset_n(rst_n),
    .up_TxPort(up_tx),
    .up_RxPort(up_rx),
    .dn_TxPort(dn_tx),
    .dn_RxPort(dn_rx),
    .rd_outstanding(rd_out),
    .wr_outstanding(wr_out),
    .err_sticky(err)
`ifdef VAI_TX_THROTTLE_STATS_EN
    ,
    .rd_stall_cycles(rd_stall),
    .wr_stall_cycles(wr_stall)
`endif
  );

  always @(negedge pClk) begin
    if (dn_tx.c0.valid === 1'b1) begin
      c0_seen++;
      last_c0_mdata = dn_tx.c0.hdr.mdata;
    end
    if (dn_tx.c1.valid === 1'b1) c1_seen++;
  end

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    up_tx = '0;
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_rd(input logic [1:0] len, input logic [15:0] md);
    up_tx.c0.valid      = 1'b1;
    up_tx.c0.hdr.cl_len = len;
    up_tx.c0.hdr.mdata  = md;
    tick();
    up_tx.c0.valid = 1'b0;
  endtask

  task automatic push_wr(input logic sop, input logic [1:0] len, input logic [63:0] d);
    up_tx.c1.valid       = 1'b1;
    up_tx.c1.hdr.sop     = sop;
    up_tx.c1.hdr.cl_len  = len;
    up_tx.c1.data        = '0;
    up_tx.c1.data[63:0]  = d;
    tick();
    up_tx.c1.valid = 1'b0;
  endtask

  initial begin
    up_tx = '0;
    dn_rx = '0;
    rst_n = 1'b0;

    // reset held 4 cycles
    repeat (4) tick();
    chk("rst_dn_c0_valid", dn_tx.c0.valid, 1'b0);
    chk("rst_dn_c1_valid", dn_tx.c1.valid, 1'b0);
    chk("rst_dn_c2_valid", dn_tx.c2.mmioRdValid, 1'b0);
    chk("rst_up_c0_rsp", up_rx.c0.rspValid, 1'b0);
    chk("rst_up_alm0", up_rx.c0TxAlmFull, 1'b1);
    chk("rst_up_alm1", up_rx.c1TxAlmFull, 1'b1);
    chk("rst_rd_out", rd_out, 8'd0);
    chk("rst_wr_out", wr_out, 8'd0);
    chk("rst_err", err, 2'b00);
    rst_n = 1'b1;
    tick();
    chk("rel_up_alm0", up_rx.c0TxAlmFull, 1'b0);
    chk("rel_up_alm1", up_rx.c1TxAlmFull, 1'b0);

    // read burst: 20 single-line reads, credit limit 16
    base = c0_seen;
    for (int i = 0; i < 20; i++) push_rd(2'd0, 16'(i));
    repeat (8) tick();
    chk("rdb_issued16", 64'(c0_seen - base), 64'd16);
    chk("rdb_rd_out16", rd_out, 8'd16);
    chk("rdb_alm0_low", up_rx.c0TxAlmFull, 1'b0);
    dn_rx.c0.rspValid       = 1'b1;
    dn_rx.c0.hdr.resp_type  = RSP_RDLINE;
    dn_rx.c0.hdr.mdata      = 16'hA5A5;
    tick();
    chk("rdb_rsp_fwd_valid", up_rx.c0.rspValid, 1'b1);
    chk("rdb_rsp_fwd_mdata", up_rx.c0.hdr.mdata, 16'hA5A5);
    chk("rdb_rd_out15", rd_out, 8'd15);
    for (int i = 1; i < 4; i++) begin
      dn_rx.c0.hdr.mdata = 16'(i);
      tick();
    end
    dn_rx.c0 = '0;
    repeat (4) tick();
    chk("rdb_issued20", 64'(c0_seen - base), 64'd20);
    chk("rdb_rd_out_final", rd_out, 8'd16);
    chk("rdb_last_mdata", last_c0_mdata, 16'd19);

    // reset mid-operation discards credits
    do_reset(2);
    chk("rst2_rd_out", rd_out, 8'd0);

    // write credit: reach 62 outstanding with single-line writes
    base = c1_seen;
    for (int i = 0; i < 62; i++) push_wr(1'b1, 2'd0, 64'(i));
    push_wr(1'b1, 2'd3, 64'hD0);
    push_wr(1'b0, 2'd3, 64'hD1);
    push_wr(1'b0, 2'd3, 64'hD2);
    push_wr(1'b0, 2'd3, 64'hD3);
    repeat (6) tick();
    chk("wr_issued62", 64'(c1_seen - base), 64'd62);
    chk("wr_out62", wr_out, 8'd62);
    chk("wr_blocked_valid", dn_tx.c1.valid, 1'b0);
    dn_rx.c1.rspValid      = 1'b1;
    dn_rx.c1.hdr.resp_type = RSP_WRLINE;
    dn_rx.c1.hdr.format    = 1'b1;
    dn_rx.c1.hdr.cl_num    = 2'd1;
    tick();
    dn_rx.c1 = '0;
    chk("wr_out60", wr_out, 8'd60);
    chk("wr_still_blocked", dn_tx.c1.valid, 1'b0);
    tick();
    chk("wr_beat0_valid", dn_tx.c1.valid, 1'b1);
    chk("wr_beat0_data", dn_tx.c1.data[63:0], 64'hD0);
    chk("wr_beat0_sop", dn_tx.c1.hdr.sop, 1'b1);
    chk("wr_out64", wr_out, 8'd64);
    tick();
    chk("wr_beat1_data", dn_tx.c1.valid ? dn_tx.c1.data[63:0] : 64'hDEAD, 64'hD1);
    tick();
    chk("wr_beat2_data", dn_tx.c1.valid ? dn_tx.c1.data[63:0] : 64'hDEAD, 64'hD2);
    tick();
    chk("wr_beat3_data", dn_tx.c1.valid ? dn_tx.c1.data[63:0] : 64'hDEAD, 64'hD3);
    tick();
    chk("wr_burst_done", dn_tx.c1.valid, 1'b0);
    chk("wr_out_final", wr_out, 8'd64);

    // upstream almost-full with downstream c0 almost-full held high
    dn_rx.c0TxAlmFull = 1'b1;
    do_reset(2);
    base = c0_seen;
    for (int i = 0; i < 7; i++) push_rd(2'd0, 16'(i));
    chk("alm_7_low", up_rx.c0TxAlmFull, 1'b0);
    push_rd(2'd0, 16'd7);
    chk("alm_8_high", up_rx.c0TxAlmFull, 1'b1);
    for (int i = 8; i < 15; i++) push_rd(2'd0, 16'(i));
    chk("alm_15_noerr", err, 2'b00);
    push_rd(2'd0, 16'd15);
    chk("alm_full_noerr", err, 2'b00);
    push_rd(2'd0, 16'd16);
    chk("alm_ovf_err", err, 2'b01);
    chk("alm_none_issued", 64'(c0_seen - base), 64'd0);
    dn_rx.c0TxAlmFull = 1'b0;
    repeat (20) tick();
    chk("alm_drained16", 64'(c0_seen - base), 64'd16);
    chk("alm_last_mdata", last_c0_mdata, 16'd15);
    chk("alm_rd_out", rd_out, 8'd16);
    chk("alm_low_again", up_rx.c0TxAlmFull, 1'b0);

    // spurious RdLine response at zero credit, plus c2 passthrough
    do_reset(2);
    dn_rx.c0.rspValid      = 1'b1;
    dn_rx.c0.hdr.resp_type = RSP_RDLINE;
    dn_rx.c0.hdr.mdata     = 16'h1234;
    up_tx.c2.mmioRdValid   = 1'b1;
    up_tx.c2.data          = 64'hCAFE_F00D_0123_4567;
    up_tx.c2.hdr.tid       = 9'h1A5;
    tick();
    dn_rx.c0 = '0;
    up_tx.c2 = '0;
    chk("unf_rd_out", rd_out, 8'd0);
    chk("unf_err", err, 2'b10);
    chk("unf_fwd_valid", up_rx.c0.rspValid, 1'b1);
    chk("unf_fwd_mdata", up_rx.c0.hdr.mdata, 16'h1234);
    chk("c2_valid", dn_tx.c2.mmioRdValid, 1'b1);
    chk("c2_data", dn_tx.c2.data, 64'hCAFE_F00D_0123_4567);
    chk("c2_tid", dn_tx.c2.hdr.tid, 9'h1A5);
    tick();
    chk("c2_valid_drop", dn_tx.c2.mmioRdValid, 1'b0);

    // same-cycle issue of a 2-line read and one RdLine return at 5
    do_reset(2);
    for (int i = 0; i < 5; i++) push_rd(2'd0, 16'(i));
    repeat (3) tick();
    chk("net_rd_out5", rd_out, 8'd5);
    up_tx.c0.valid      = 1'b1;
    up_tx.c0.hdr.cl_len = 2'd1;
    up_tx.c0.hdr.mdata  = 16'h0BEE;
    tick();
    up_tx.c0.valid         = 1'b0;
    dn_rx.c0.rspValid      = 1'b1;
    dn_rx.c0.hdr.resp_type = RSP_RDLINE;
    tick();
    dn_rx.c0 = '0;
    chk("net_issue_valid", dn_tx.c0.valid, 1'b1);
    chk("net_issue_len", dn_tx.c0.hdr.cl_len, 2'd1);
    chk("net_rd_out6", rd_out, 8'd6);
    chk("net_err", err, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
